// File: rtl/hisoc_test_seq_pkg.sv
// HISOC test sequencer shared types.
// FSM state and per-test verdict encodings.
package hisoc_test_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    RECORD,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    V_PASS,
    V_FAIL,
    V_TMO
  } verdict_t;

endpackage

// File: rtl/hisoc_test_seq_if.sv
// Program-image load stream into the sequencer.
// valid/ready handshake, one ROM word per beat.
interface hisoc_test_seq_if #(
  parameter int DATA_W = 32
);
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;

  modport master (
    output ld_valid,
    output ld_data,
    output ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    output ld_ready
  );
endinterface

// File: rtl/hisoc_test_wdog.sv
// Cycle watchdog: counts while enabled, flags the LIMIT-th cycle.
// clear restarts from zero; expire is valid only while enabled.
module hisoc_test_wdog #(
  parameter int LIMIT = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt;

  assign expire = enable && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hisoc_test_seq.sv
// Multi-program test sequencer: load ROM image, reset/run core,
// record pass/fail/timeout per test across TEST_NUM programs.
module hisoc_test_seq
  import hisoc_test_seq_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int TEST_NUM    = 37,
  parameter int IDX_W       = 6,
  parameter int TIMEOUT_CYC = 500,
  parameter int RST_CYC     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  hisoc_test_seq_if.slave     ld,
  output logic                rom_we,
  output logic [ADDR_W-1:0]   rom_waddr,
  output logic [DATA_W-1:0]   rom_wdata,
  output logic                core_rst,
  output logic                core_enable,
  input  logic                core_done,
  input  logic                core_pass,
  output logic [IDX_W-1:0]    test_idx,
  output logic                busy,
  output logic                all_done,
  output logic [TEST_NUM-1:0] result,
  output logic [TEST_NUM-1:0] timeout,
  output logic [TEST_NUM-1:0] ovf,
  output logic [IDX_W:0]      pass_cnt,
  output logic [IDX_W:0]      fail_cnt
);

  state_t            state;
  verdict_t          verdict;
  logic [ADDR_W-1:0] ptr;
  logic              hold_on;
  logic              beat;
  logic              ovf_cur;
  logic              last_idx;
  logic              run_exp;
  logic              hold_exp;

  assign beat     = ld.ld_valid & ld.ld_ready;
  assign ovf_cur  = ovf[test_idx];
  assign last_idx = (test_idx == IDX_W'(TEST_NUM - 1));

  assign ld.ld_ready = (state == LOAD);
  assign rom_we      = beat & ~ovf_cur;
  assign rom_waddr   = ptr;
  assign rom_wdata   = ld.ld_data;

  // core sees one disabled reset cycle before enable rises in HOLD
  assign core_rst    = (state != RUN);
  assign core_enable = (state == RUN) | ((state == HOLD) & hold_on);
  assign busy        = (state != IDLE) && (state != DONE);
  assign all_done    = (state == DONE);

  hisoc_test_wdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_run_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != RUN),
    .enable (state == RUN),
    .expire (run_exp)
  );

  hisoc_test_wdog #(
    .LIMIT (RST_CYC)
  ) u_hold_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != HOLD),
    .enable (state == HOLD),
    .expire (hold_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      verdict  <= V_FAIL;
      ptr      <= '0;
      hold_on  <= 1'b0;
      test_idx <= '0;
      result   <= '0;
      timeout  <= '0;
      ovf      <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      hold_on <= (state == HOLD);
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LOAD;
            ptr      <= '0;
            test_idx <= '0;
            result   <= '0;
            timeout  <= '0;
            ovf      <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
          end
        end
        LOAD: begin
          if (beat) begin
            ptr <= ptr + ADDR_W'(1);
            if (ld.ld_last) begin
              state <= HOLD;
            end else if (ptr == '1) begin
              // image longer than the ROM: drop the tail
              ovf[test_idx] <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (hold_exp) state <= RUN;
        end
        RUN: begin
          if (core_done) begin
            verdict <= core_pass ? V_PASS : V_FAIL;
            state   <= RECORD;
          end else if (run_exp) begin
            verdict <= V_TMO;
            state   <= RECORD;
          end
        end
        RECORD: begin
          unique case (verdict)
            V_PASS: begin
              result[test_idx] <= 1'b1;
              pass_cnt         <= pass_cnt + (IDX_W+1)'(1);
            end
            V_TMO: begin
              timeout[test_idx] <= 1'b1;
              fail_cnt          <= fail_cnt + (IDX_W+1)'(1);
            end
            default: begin
              fail_cnt <= fail_cnt + (IDX_W+1)'(1);
            end
          endcase
          if (last_idx) begin
            state <= DONE;
          end else begin
            test_idx <= test_idx + IDX_W'(1);
            ptr      <= '0;
            state    <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hisoc_test_seq.sv
// Directed bench for hisoc_test_seq (2 tests, 4-word ROM).
// Hand-computed expectations checked with immediate assertions.
module tb_hisoc_test_seq;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;
  localparam int TNUM   = 2;
  localparam int IDX_W  = 1;
  localparam int TMO    = 500;
  localparam int RCYC   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              core_done;
  logic              core_pass;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [DATA_W-1:0] rom_wdata;
  logic              core_rst;
  logic              core_enable;
  logic [IDX_W-1:0]  test_idx;
  logic              busy;
  logic              all_done;
  logic [TNUM-1:0]   result;
  logic [TNUM-1:0]   timeout;
  logic [TNUM-1:0]   ovf;
  logic [IDX_W:0]    pass_cnt;
  logic [IDX_W:0]    fail_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  hisoc_test_seq_if #(.DATA_W(DATA_W)) ld_if ();

  hisoc_test_seq #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TEST_NUM    (TNUM),
    .IDX_W       (IDX_W),
    .TIMEOUT_CYC (TMO),
    .RST_CYC     (RCYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ld          (ld_if.slave),
    .rom_we      (rom_we),
    .rom_waddr   (rom_waddr),
    .rom_wdata   (rom_wdata),
    .core_rst    (core_rst),
    .core_enable (core_enable),
    .core_done   (core_done),
    .core_pass   (core_pass),
    .test_idx    (test_idx),
    .busy        (busy),
    .all_done    (all_done),
    .result      (result),
    .timeout     (timeout),
    .ovf         (ovf),
    .pass_cnt    (pass_cnt),
    .fail_cnt    (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("go_ready", ld_if.ld_ready, 1);
    chk("go_busy", busy, 1);
    chk("go_idx", test_idx, 0);
    chk("go_res", result, 0);
    chk("go_pass", pass_cnt, 0);
    chk("go_fail", fail_cnt, 0);
  endtask

  task automatic load(input int n, input logic [31:0] base,
                      input bit inc, input bit gaps, input int nwr);
    for (int i = 0; i < n; i++) begin
      logic [31:0] d;
      int g;
      d = inc ? base + 32'(i) : base;
      g = gaps ? int'($urandom_range(0, 3)) : 0;
      for (int k = 0; k < g; k++) begin
        ld_if.ld_valid = 1'b0;
        #2;
        chk("gap_we", rom_we, 0);
        step();
      end
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = d;
      ld_if.ld_last  = (i == n - 1);
      #2;
      chk("ld_ready", ld_if.ld_ready, 1);
      chk("rom_we", rom_we, (i < nwr));
      if (i < nwr) begin
        chk("waddr", rom_waddr, i);
        chk("wdata", rom_wdata, d);
      end
      step();
    end
    ld_if.ld_valid = 1'b0;
    ld_if.ld_last  = 1'b0;
  endtask

  // done_at < 0: never signal done and expect a timeout
  task automatic hold_run(input int done_at, input bit pass);
    chk("hold0_rst", core_rst, 1);
    chk("hold0_en", core_enable, 0);
    step();
    chk("hold1_rst", core_rst, 1);
    chk("hold1_en", core_enable, 1);
    step();
    chk("run_rst", core_rst, 0);
    chk("run_en", core_enable, 1);
    if (done_at >= 0) begin
      repeat (done_at) step();
      core_done = 1'b1;
      core_pass = pass;
      step();
      core_done = 1'b0;
      core_pass = 1'b0;
      chk("rec_rst", core_rst, 1);
      chk("rec_en", core_enable, 0);
    end else begin
      int n;
      n = 0;
      while (!core_rst && n < 600) begin
        step();
        n++;
      end
      chk("tmo_cycles", n, TMO);
    end
    step();
  endtask

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    core_done      = 1'b0;
    core_pass      = 1'b0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = '0;
    ld_if.ld_last  = 1'b0;
    step();
    step();
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_en", core_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_ready", ld_if.ld_ready, 0);
    chk("rst_we", rom_we, 0);
    chk("rst_result", result, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_pass", pass_cnt, 0);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_idx", test_idx, 0);
    rst = 1'b0;
    step();

    // two passing tests, second with gapped valid
    go();
    load(4, 32'h0000_0013, 1'b0, 1'b0, 4);
    hold_run(10, 1'b1);
    chk("a_idx", test_idx, 1);
    chk("a_res0", result, 2'b01);
    chk("a_pass0", pass_cnt, 1);
    chk("a_ready", ld_if.ld_ready, 1);
    load(4, 32'hA000_0000, 1'b1, 1'b1, 4);
    hold_run(10, 1'b1);
    chk("a_all_done", all_done, 1);
    chk("a_busy", busy, 0);
    chk("a_result", result, 2'b11);
    chk("a_pass", pass_cnt, 2);
    chk("a_fail", fail_cnt, 0);
    chk("a_tmo", timeout, 0);
    chk("a_ovf", ovf, 0);
    chk("a_core_rst", core_rst, 1);
    core_done = 1'b1;
    core_pass = 1'b1;
    step();
    core_done = 1'b0;
    core_pass = 1'b0;
    step();
    chk("a_ign_pass", pass_cnt, 2);
    chk("a_ign_done", all_done, 1);

    // overflow + timeout, then done on the expiry cycle
    go();
    load(6, 32'hB000_0000, 1'b1, 1'b1, 4);
    chk("b_ovf0", ovf, 2'b01);
    hold_run(-1, 1'b0);
    chk("b_tmo", timeout, 2'b01);
    chk("b_res", result, 2'b00);
    chk("b_fail", fail_cnt, 1);
    chk("b_pass", pass_cnt, 0);
    chk("b_idx", test_idx, 1);
    chk("b_ready", ld_if.ld_ready, 1);
    load(4, 32'hC000_0000, 1'b1, 1'b0, 4);
    chk("b_ovf1", ovf, 2'b01);
    hold_run(TMO - 1, 1'b1);
    chk("b_res_fin", result, 2'b10);
    chk("b_tmo_fin", timeout, 2'b01);
    chk("b_pass_fin", pass_cnt, 1);
    chk("b_fail_fin", fail_cnt, 1);
    chk("b_all_done", all_done, 1);

    // reset during RUN of test 1, then a clean rerun
    go();
    load(4, 32'hD000_0000, 1'b1, 1'b0, 4);
    hold_run(3, 1'b1);
    chk("c_pass0", pass_cnt, 1);
    load(4, 32'hE000_0000, 1'b1, 1'b1, 4);
    step();
    step();
    step();
    step();
    chk("c_in_run", core_rst, 0);
    rst = 1'b1;
    step();
    chk("c_busy", busy, 0);
    chk("c_core_rst", core_rst, 1);
    chk("c_core_en", core_enable, 0);
    chk("c_result", result, 0);
    chk("c_pass", pass_cnt, 0);
    chk("c_idx", test_idx, 0);
    chk("c_all_done", all_done, 0);
    rst = 1'b0;
    step();
    go();
    load(1, 32'hF000_0000, 1'b1, 1'b0, 1);
    hold_run(5, 1'b0);
    chk("c_fail0", fail_cnt, 1);
    chk("c_res0", result, 2'b00);
    chk("c_idx1", test_idx, 1);
    load(2, 32'hF100_0000, 1'b1, 1'b1, 2);
    hold_run(0, 1'b1);
    chk("c_result_fin", result, 2'b10);
    chk("c_pass_fin", pass_cnt, 1);
    chk("c_fail_fin", fail_cnt, 1);
    chk("c_tmo_fin", timeout, 0);
    chk("c_ovf_fin", ovf, 0);
    chk("c_all_done_fin", all_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
